// File: rtl/hex_updown_display.sv
// Up/down N-digit hex counter driven by two debounced push-buttons, shown on a scanned 7-segment display.
// Optional press-and-hold auto-repeat is enabled by defining HEXDISP_AUTOREPEAT_EN.

module hex_updown_btn #(
  parameter int DEBOUNCE_BITS = 16,
  parameter int REPEAT_DELAY  = 6000000,
  parameter int REPEAT_RATE   = 1200000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n,
  output logic evt
);
  logic                     sync1, sync2;
  logic                     db;
  logic [DEBOUNCE_BITS-1:0] cnt;
  logic                     mismatch, full, db_rise;

  assign mismatch = (~sync2) != db;
  assign full     = &cnt;
  assign db_rise  = mismatch & full & ~db;

  // Synchronisers reset to the released (high) level so no press is seen out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      db    <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= btn_n;
      sync2 <= sync1;
      if (!mismatch) begin
        cnt <= '0;
      end else if (full) begin
        cnt <= '0;
        db  <= ~db;
      end else begin
        cnt <= cnt + DEBOUNCE_BITS'(1);
      end
    end
  end

`ifdef HEXDISP_AUTOREPEAT_EN
  localparam int TMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rep_state_t;
  rep_state_t    state;
  logic [TW-1:0] tmr;
  logic          db_fall;

  assign db_fall = mismatch & full & db;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      tmr   <= '0;
      evt   <= 1'b0;
    end else begin
      evt <= db_rise;
      case (state)
        IDLE: begin
          if (db_rise) begin
            state <= DELAY;
            tmr   <= TW'(REPEAT_DELAY - 1);
          end
        end
        DELAY: begin
          if (db_fall) begin
            state <= IDLE;
          end else if (tmr == '0) begin
            state <= REPEAT;
            tmr   <= TW'(REPEAT_RATE - 1);
            evt   <= 1'b1;
          end else begin
            tmr <= tmr - TW'(1);
          end
        end
        REPEAT: begin
          if (db_fall) begin
            state <= IDLE;
          end else if (tmr == '0) begin
            tmr <= TW'(REPEAT_RATE - 1);
            evt <= 1'b1;
          end else begin
            tmr <= tmr - TW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = (REPEAT_DELAY > REPEAT_RATE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) evt <= 1'b0;
    else       evt <= db_rise;
  end
`endif
endmodule

module hex_updown_display #(
  parameter int DIGITS        = 2,
  parameter int DEBOUNCE_BITS = 16,
  parameter int SCAN_BITS     = 10,
  parameter int REPEAT_DELAY  = 6000000,
  parameter int REPEAT_RATE   = 1200000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  btn_up_n,
  input  logic                  btn_down_n,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     digit_sel,
  output logic [4*DIGITS-1:0]   value,
  output logic                  step
);
  localparam int VW = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic                 ev_up, ev_dn, step_pend;
  logic [SCAN_BITS-1:0] pre;
  logic [IW-1:0]        idx;
  logic [3:0]           nib;

  hex_updown_btn #(.DEBOUNCE_BITS(DEBOUNCE_BITS), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE))
    u_btn_up (.clk(clk), .reset(reset), .btn_n(btn_up_n), .evt(ev_up));
  hex_updown_btn #(.DEBOUNCE_BITS(DEBOUNCE_BITS), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE))
    u_btn_dn (.clk(clk), .reset(reset), .btn_n(btn_down_n), .evt(ev_dn));

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
    endcase
  endfunction

  // Simultaneous up and down events cancel; step lags the value change by one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value     <= '0;
      step_pend <= 1'b0;
      step      <= 1'b0;
    end else begin
      step_pend <= 1'b0;
      step      <= step_pend;
      if (ev_up ^ ev_dn) begin
        value     <= ev_up ? value + VW'(1) : value - VW'(1);
        step_pend <= 1'b1;
      end
    end
  end

  assign nib = value[{idx, 2'b00} +: 4];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre       <= '0;
      idx       <= '0;
      digit_sel <= DIGITS'(1);
      seg       <= 7'h3F;
    end else begin
      pre <= pre + SCAN_BITS'(1);
      if (&pre) idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
      digit_sel <= DIGITS'(1) << idx;
      seg       <= hex7(nib);
    end
  end
endmodule

// File: tb/tb_hex_updown_display.sv
// Directed bench for hex_updown_display: debounce latency, bounce rejection, wrap, cancel, scan, auto-repeat.
module tb_hex_updown_display;
  localparam int DIGITS = 2;

  logic       clk = 1'b0;
  logic       rst, up_n, dn_n;
  logic [6:0] seg;
  logic [1:0] digit_sel;
  logic [7:0] value;
  logic       step;

  int passes = 0, total = 0, step_cnt = 0, cyc = 0, s0 = 0;

  hex_updown_display #(.DIGITS(DIGITS), .DEBOUNCE_BITS(4), .SCAN_BITS(2),
                       .REPEAT_DELAY(40), .REPEAT_RATE(10)) dut (
    .clk(clk), .reset(rst), .btn_up_n(up_n), .btn_down_n(dn_n),
    .seg(seg), .digit_sel(digit_sel), .value(value), .step(step));

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  always @(posedge clk) if (step === 1'b1) step_cnt <= step_cnt + 1;

  function automatic logic [6:0] hexpat(input logic [3:0] n);
    case (n)
      4'h0: hexpat = 7'h3F;  4'h1: hexpat = 7'h06;  4'h2: hexpat = 7'h5B;  4'h3: hexpat = 7'h4F;
      4'h4: hexpat = 7'h66;  4'h5: hexpat = 7'h6D;  4'h6: hexpat = 7'h7D;  4'h7: hexpat = 7'h07;
      4'h8: hexpat = 7'h7F;  4'h9: hexpat = 7'h6F;  4'hA: hexpat = 7'h77;  4'hB: hexpat = 7'h7C;
      4'hC: hexpat = 7'h39;  4'hD: hexpat = 7'h5E;  4'hE: hexpat = 7'h79;  default: hexpat = 7'h71;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passes++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Display shows the digit selected one cycle earlier; prescaler wraps every 4 cycles.
  task automatic chk_disp(input string tag, input logic [7:0] v);
    int i;
    i = ((cyc - 1) >> 2) & 1;
    chk({tag, "_sel"}, digit_sel, (i == 1) ? 32'h2 : 32'h1);
    chk({tag, "_seg"}, seg, hexpat((i == 1) ? v[7:4] : v[3:0]));
  endtask

  initial begin
    rst = 1'b1; up_n = 1'b1; dn_n = 1'b1;
    tick(3);
    chk("rst_value", value, 0);
    chk("rst_step", step, 0);
    chk("rst_sel", digit_sel, 1);
    chk("rst_seg", seg, 7'h3F);
    rst = 1'b0;

    for (int c = 0; c < 100; c++) begin
      tick(1);
      chk_disp("idle", 8'h00);
    end
    chk("idle_value", value, 0);
    chk("idle_steps", step_cnt, 0);

    // clean up press: value changes 19 edges after raw edge, step one edge later
    s0 = step_cnt;
    up_n = 1'b0;
    tick(18); chk("up_before", value, 0);
    tick(1);  chk("up_after", value, 1);
              chk("step_not_yet", step, 0);
    tick(1);  chk("step_high", step, 1);
    tick(1);  chk("step_low", step, 0);
    tick(9);  up_n = 1'b1;
    tick(30);
    chk("up_hold_value", value, 1);
    chk("up_steps", step_cnt - s0, 1);
    chk_disp("disp01", 8'h01);

    // bouncy press: 1-cycle bounce every 10 cycles, count from last bounce
    s0 = step_cnt;
    up_n = 1'b0;
    for (int b = 0; b < 5; b++) begin
      tick(9); up_n = 1'b1;
      tick(1); up_n = 1'b0;
    end
    tick(18); chk("bounce_before", value, 1);
    tick(1);  chk("bounce_after", value, 2);
    tick(10); up_n = 1'b1;
    tick(30);
    chk("bounce_steps", step_cnt - s0, 1);
    chk("bounce_value", value, 2);

    rst = 1'b1; tick(2);
    chk("rst2_value", value, 0);
    rst = 1'b0;

    // down wrap 00 -> FF
    s0 = step_cnt;
    dn_n = 1'b0;
    tick(19); chk("down_wrap", value, 8'hFF);
    tick(1);  chk("down_step", step, 1);
    tick(10); dn_n = 1'b1;
    tick(30);
    chk("down_steps", step_cnt - s0, 1);
    for (int c = 0; c < 8; c++) begin
      tick(1);
      chk_disp("dispFF", 8'hFF);
    end

    // up wrap FF -> 00
    s0 = step_cnt;
    up_n = 1'b0;
    tick(19); chk("up_wrap", value, 8'h00);
    tick(10); up_n = 1'b1;
    tick(30);
    chk("up_wrap_steps", step_cnt - s0, 1);
    chk_disp("disp00", 8'h00);

    // reset mid-debounce abandons the press
    s0 = step_cnt;
    up_n = 1'b0;
    tick(10); rst = 1'b1;
    tick(1);  up_n = 1'b1;
    tick(1);  rst = 1'b0;
    tick(40);
    chk("rst_mid_value", value, 0);
    chk("rst_mid_steps", step_cnt - s0, 0);

    // simultaneous press cancels
    s0 = step_cnt;
    up_n = 1'b0; dn_n = 1'b0;
    tick(25);
    chk("both_value", value, 0);
    chk("both_steps", step_cnt - s0, 0);
    up_n = 1'b1; dn_n = 1'b1;
    tick(30);
    chk("both_release", value, 0);

`ifdef HEXDISP_AUTOREPEAT_EN
    s0 = step_cnt;
    up_n = 1'b0;
    tick(19); chk("rep_first", value, 1);
    tick(39); chk("rep_delay_pre", value, 1);
    tick(1);  chk("rep_delay", value, 2);
    tick(10); chk("rep_rate", value, 3);
    tick(26); up_n = 1'b1;
    tick(40);
    chk("rep_total", value, 7);
    chk("rep_steps", step_cnt - s0, 7);
    tick(50);
    chk("rep_idle", value, 7);

    up_n = 1'b0;
    tick(70); rst = 1'b1;
    tick(1);  up_n = 1'b1;
    tick(1);  rst = 1'b0;
    chk("rep_rst_value", value, 0);
    s0 = step_cnt;
    tick(100);
    chk("rep_rst_after", value, 0);
    chk("rep_rst_steps", step_cnt - s0, 0);
`else
    s0 = step_cnt;
    up_n = 1'b0;
    tick(120);
    chk("hold_value", value, 1);
    up_n = 1'b1;
    tick(30);
    chk("hold_steps", step_cnt - s0, 1);
`endif

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule

// File: doc/hex_updown_display.md
# hex_updown_display

Parametrised successor to the single-button hex counter front panel. Two raw active-low push-buttons (up/down) are synchronised and debounced. They step an N-digit hexadecimal counter, and the count is shown on a time-multiplexed common-segment 7-segment display. It sits between the board pins (buttons, segment and digit-select lines) and any logic that consumes the current count.

## Interface
Parameters:
- DIGITS, 2: number of hex digits displayed and counted (1..8); counter width 4*DIGITS
- DEBOUNCE_BITS, 16: debounce counter width; input must be stable 2^DEBOUNCE_BITS cycles
- SCAN_BITS, 10: display scan prescaler width; each digit lit for 2^SCAN_BITS cycles
- REPEAT_DELAY, 6000000: cycles a button is held before the first auto-repeat step
- REPEAT_RATE, 1200000: cycles between subsequent auto-repeat steps

Ports:
- clk  in  1  single system clock
- reset  in  1  asynchronous, active-high reset
- btn_up_n  in  1  raw up button, active-low, asynchronous to clk
- btn_down_n  in  1  raw down button, active-low, asynchronous to clk
- seg  out  7  segment drive, active-high, seg[0]=a … seg[6]=g
- digit_sel  out  DIGITS  one-hot digit enable, active-high, bit 0 = least significant digit
- value  out  4*DIGITS  current count
- step  out  1  one-cycle pulse when value changed on the previous cycle

## Operation
- Each button path: 2-flop synchroniser, then debouncer with debounced state `db` (1 = pressed).
  - Counter clears whenever the synchronised level equals `db`, and increments otherwise.
  - When the counter is at all-ones and increments, `db` toggles and the counter clears.
- A press event is a one-cycle pulse, registered on the same edge that `db` goes 0→1. Release generates no event.
- Counter update on the cycle after an event:
  - up only: value+1 mod 2^(4*DIGITS), wrapping FF…F→0.
  - down only: value−1 mod 2^(4*DIGITS), wrapping 0→FF…F.
  - up and down events on the same cycle: no change and no step.
- `step` asserts for the cycle after value changes.
- Display scan:
  - Prescaler counts continuously. On wrap, digit index advances 0→1→…→DIGITS−1→0.
  - digit_sel = one-hot(index). seg = hex pattern of nibble value[4*index+3:4*index].
- Hex patterns (g..a): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
- Reset, asynchronous:
  - Outputs: value=0, step=0, digit_sel=1, seg=3F.
  - Internal state: synchronisers read as released, db=0, all counters 0, repeat FSM IDLE.
  - Reset asserted mid-debounce or mid-repeat abandons the operation; no event is emitted after release.

## Timing
- Raw edge to `db` change:
  - 2 synchroniser cycles + 2^DEBOUNCE_BITS cycles of stable mismatch.
  - Any glitch back to the `db` level restarts the count.
- `db` rise → event (same edge) → value updated +1 cycle → `step` high the following cycle for exactly 1 cycle.
- seg/digit_sel are registered.
  - They change 1 cycle after the prescaler wrap.
  - They reflect a new value 1 cycle after value changes.
- DIGITS=1: digit_sel constantly 1 and index never advances.

## Configuration
- `HEXDISP_AUTOREPEAT_EN` defined:
  - Per-button repeat FSM with states IDLE → DELAY → REPEAT.
  - IDLE→DELAY on `db` rise (initial event as normal).
  - DELAY→REPEAT after REPEAT_DELAY cycles held, emitting an event.
  - In REPEAT, emits an event every REPEAT_RATE cycles.
  - Any state→IDLE when `db` falls.
  - Repeat events obey the same simultaneous-event rule: both buttons generating events on the same cycle causes no change.
- Undefined: only the press edge generates an event; holding a button has no further effect. REPEAT_DELAY and REPEAT_RATE are ignored.

## Test plan
Bench parameters: DIGITS=2, DEBOUNCE_BITS=4, SCAN_BITS=2, REPEAT_DELAY=40, REPEAT_RATE=10.
- Reset then idle 100 cycles → value=00, step never asserts, digit_sel alternates 01/10 every 4 cycles, seg=3F on both digits.
- Clean up press held 30 cycles → value=01 exactly 2+16+1 cycles after the edge; step is a single pulse; only one increment without the macro.
- Up press with a 1-cycle bounce every 10 cycles for 50 cycles, then stable → exactly one increment, counted from the last bounce.
- From value=00, one down press → FF, with seg FF=71 on both digits. From FF, one up press → 00.
- Both buttons pressed on the same cycle → db rises together, value unchanged, step stays 0.
- With `HEXDISP_AUTOREPEAT_EN`, up held 100 cycles after db rise → increments at +0, +40, +50, +60… (7 total, value=07); release returns the FSM to IDLE. Reset asserted mid-hold → value=00 and no further steps.
